// File: rtl/hex_display_pkg.sv
// Shared constants for the hex display PIO: register map and 7-segment patterns.
package hex_display_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_SET    = 3'd4;
  localparam logic [2:0] ADDR_CLR    = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 15 is leftmost.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_display_pio_if.sv
// Avalon-MM slave bus bundle for the hex display PIO.
interface hex_display_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hex_seg_decode.sv
// One digit: hex nibble to active-low 7-segment pattern, with forced blank.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] segs
);
  assign segs = blank ? SEG_BLANK : SEG_LUT[nibble];
endmodule

// File: rtl/hex_display_pio.sv
// Memory-mapped hex digit bank with set/clear, per-digit blanking, blink and 7-seg decode.
module hex_display_pio
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 26
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_pio_if.slave        bus,
  output logic [4*NUM_DIGITS-1:0] digit_out,
  output logic [7*NUM_DIGITS-1:0] hex_segs
);
  localparam int W = 4*NUM_DIGITS;

  logic [W-1:0]          data_q, data_d;
  logic [NUM_DIGITS-1:0] enable_q, enable_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [CNT_W-1:0]      period_q, period_d;
  logic [CNT_W-1:0]      presc_q, presc_d;
  logic                  phase_q, phase_d;
  logic                  wr;

  assign wr = bus.chipselect & ~bus.write_n;

  always_comb begin
    data_d   = data_q;
    enable_d = enable_q;
    blink_d  = blink_q;
    period_d = period_q;
    presc_d  = presc_q;
    phase_d  = phase_q;

    if (period_q == '0) begin
      presc_d = '0;
      phase_d = 1'b1;
    end else if (presc_q == period_q - CNT_W'(1)) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end else begin
      presc_d = presc_q + CNT_W'(1);
    end

    if (wr) begin
      unique case (bus.address)
        ADDR_DATA:   data_d   = bus.writedata[W-1:0];
        ADDR_ENABLE: enable_d = bus.writedata[NUM_DIGITS-1:0];
        ADDR_BLINK:  blink_d  = bus.writedata[NUM_DIGITS-1:0];
        ADDR_PERIOD: begin
          // A period write restarts the blink pattern with digits on.
          period_d = bus.writedata[CNT_W-1:0];
          presc_d  = '0;
          phase_d  = 1'b1;
        end
        ADDR_SET:    data_d   = data_q | bus.writedata[W-1:0];
        ADDR_CLR:    data_d   = data_q & ~bus.writedata[W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q   <= '0;
      enable_q <= '1;
      blink_q  <= '0;
      period_q <= '0;
      presc_q  <= '0;
      phase_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      enable_q <= enable_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:   bus.readdata[W-1:0]          = data_q;
      ADDR_ENABLE: bus.readdata[NUM_DIGITS-1:0] = enable_q;
      ADDR_BLINK:  bus.readdata[NUM_DIGITS-1:0] = blink_q;
      ADDR_PERIOD: bus.readdata[CNT_W-1:0]      = period_q;
      default: ;
    endcase
  end

  assign digit_out = data_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic vis;
    assign vis = enable_q[i] & (~blink_q[i] | phase_q);
    hex_seg_decode u_dec (
      .nibble (data_q[4*i +: 4]),
      .blank  (~vis),
      .segs   (hex_segs[7*i +: 7])
    );
  end

endmodule

// File: doc/hex_display_pio.md
# hex_display_pio

Parametrised Avalon-MM output peripheral that holds a bank of hexadecimal digits and drives them onto seven-segment displays. It sits on the system interconnect as a memory-mapped slave next to the other PIOs. It replaces a single raw 16-bit output register with the following: configurable digit count, atomic bit set/clear, per-digit blanking, hardware blink with a programmable period, and on-chip 7-segment decode.

## Interface
- NUM_DIGITS, default 4: number of hex digits, legal range 1..8.
- CNT_W, default 26: width of the blink prescaler counter and of the BLINK_PERIOD register.
- clk  in  1: system clock.
- reset_n  in  1: reset, asynchronous, active-low.
- address  in  3: word address of the register.
- chipselect  in  1: slave select.
- write_n  in  1: active-low write strobe.
- writedata  in  32: write data.
- readdata  out  32: read data, zero-extended, combinational from address (read latency 0).
- digit_out  out  4*NUM_DIGITS: raw digit nibbles; digit 0 is bits [3:0].
- hex_segs  out  7*NUM_DIGITS: active-low segments per digit, bits {g,f,e,d,c,b,a}; digit 0 is bits [6:0].

## Operation
- Register map (W = 4*NUM_DIGITS):
  - 0 DATA (rw, W bits)
  - 1 ENABLE (rw, NUM_DIGITS bits)
  - 2 BLINK (rw, NUM_DIGITS bits)
  - 3 PERIOD (rw, CNT_W bits)
  - 4 SET (wo): DATA |= writedata[W-1:0]
  - 5 CLR (wo): DATA &= ~writedata[W-1:0]
  - 6, 7 reserved
- Reads of SET, CLR and reserved addresses return 0. Writes to reserved addresses are ignored.
- A write occurs when chipselect=1 and write_n=0. Upper writedata bits beyond each register's width are ignored. Readback zero-fills them.
- Reset values:
  - DATA=0
  - ENABLE=all ones
  - BLINK=0
  - PERIOD=0
  - prescaler=0
  - blink_phase=1
  - digit_out=0
  - hex_segs = 7'h40 per digit (shows "0")
- Blink prescaler behaviour:
  - If PERIOD=0, the prescaler holds at 0 and blink_phase holds at 1.
  - Otherwise the prescaler increments every clk. When prescaler==PERIOD-1, it wraps to 0 and blink_phase toggles. The full on+off cycle is 2*PERIOD clocks.
- Blink restart: any write to PERIOD clears the prescaler to 0 and sets blink_phase=1 on the same edge.
- Digit i is visible when ENABLE[i] && (!BLINK[i] || blink_phase).
  - Visible digit: hex_segs[i] = decode(DATA nibble i).
  - Blanked digit: hex_segs[i] = 7'h7F.
  - digit_out always reflects DATA, independent of blanking.
- Decode, active-low: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.

## Timing
- Register writes take effect on the rising clk edge of the write cycle. Outputs update at that same edge, because decode is combinational from registered state.
- readdata is valid in the same cycle as address. No wait states.
- Only one register is written per cycle, because the Avalon-MM bus carries one access per cycle. SET and CLR therefore never collide with a DATA write.
- Reset mid-blink immediately forces all registers and blink_phase to their reset values, asynchronously.
- When PERIOD changes from nonzero to 0, blink_phase is forced to 1 on that edge.
- Prescaler wrap and a PERIOD write in the same cycle: the PERIOD write wins (counter=0, phase=1).

## Structure
- Package hex_display_pkg holds:
  - register address constants (ADDR_DATA..ADDR_CLR)
  - SEG_BLANK = 7'h7F
  - the 16-entry segment lookup constant
- Sub-module hex_seg_decode: 4-bit nibble plus a blank input in, 7-bit active-low segments out. The top level instantiates it NUM_DIGITS times in a generate loop.
- The top level contains the register file, the SET/CLR logic, the prescaler and the read mux.

## Test plan
- Reset: release reset_n. Required: readdata at addresses 0..3 = 0, 0xF, 0, 0; hex_segs = 0x40 in every digit; digit_out = 0.
- DATA and decode: write DATA=0x1A2F. Required: digit_out=0x1A2F; hex_segs digits 0..3 = 0E, 24, 08, 79; DATA readback = 0x1A2F.
- SET/CLR: from DATA=0x00F0, write SET=0x0F00, then CLR=0x0030. Required: DATA reads 0x0FC0; readback of address 4 = 0.
- Blanking: write ENABLE=0b0101. Required: digits 1 and 3 = 0x7F, digits 0 and 2 decoded; digit_out unchanged.
- Blink: PERIOD=4, BLINK=0b0001. Required: digit 0 is on for 4 clk, off for 4 clk, repeating; other digits steady. A PERIOD write restarts the pattern with digit 0 on. Writing PERIOD=0 makes digit 0 steady on.
- Reset mid-blink: assert reset_n low while blink_phase=0. Required: all registers and outputs return to reset values immediately; after release, digits show "0" steady.
